// File: rtl/pipeline_hazard_controller.sv
// Hazard and stall sequencing for the RV32 5-stage core: load-use bubbles, mul/div holds,
// wrong-path flushes, and a saturating stall-cycle counter for performance monitoring.
module pipeline_hazard_controller #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       fd_rs1_i,
  input  logic [4:0]       fd_rs2_i,
  input  logic             fd_uses_rs1_i,
  input  logic             fd_uses_rs2_i,
  input  logic [4:0]       de_rd_i,
  input  logic             de_is_load_i,
  input  logic             de_is_muldiv_i,
  input  logic             ex_muldiv_done_i,
  input  logic             pcsrc_i,
  output logic             pc_stall_o,
  output logic             fd_stall_o,
  output logic             de_stall_o,
  output logic             fd_flush_o,
  output logic             de_flush_o,
  output logic             md_timeout_o,
  output logic [CNT_W-1:0] stall_count_o
);

  localparam int WC_W = $clog2(MD_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MD_WAIT} state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic            luh;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // x0 is never a real destination, so it can never create a hazard.
  assign luh = de_is_load_i && (de_rd_i != 5'd0) &&
               ((fd_uses_rs1_i && (fd_rs1_i == de_rd_i)) ||
                (fd_uses_rs2_i && (fd_rs2_i == de_rd_i)));

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    pc_stall_o   = 1'b0;
    fd_stall_o   = 1'b0;
    de_stall_o   = 1'b0;
    fd_flush_o   = 1'b0;
    de_flush_o   = 1'b0;
    md_timeout_o = 1'b0;
    if (rst_i) begin
      fd_flush_o = 1'b1;
      de_flush_o = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (pcsrc_i) begin
            // Decode holds a wrong-path instruction, so any hazard it raises is moot.
            fd_flush_o = 1'b1;
            de_flush_o = 1'b1;
          end else if (de_is_muldiv_i && !ex_muldiv_done_i) begin
            pc_stall_o   = 1'b1;
            fd_stall_o   = 1'b1;
            de_stall_o   = 1'b1;
            state_nxt    = MD_WAIT;
            wait_cnt_nxt = WC_W'(1);
          end else if (luh) begin
            pc_stall_o = 1'b1;
            fd_stall_o = 1'b1;
            de_flush_o = 1'b1;
            state_nxt  = LOAD_STALL;
          end
        end
        LOAD_STALL: begin
          state_nxt = RUN;
        end
        MD_WAIT: begin
          if (ex_muldiv_done_i) begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
          end else if (wait_cnt == WC_W'(MD_TIMEOUT)) begin
            md_timeout_o = 1'b1;
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
          end else begin
            pc_stall_o   = 1'b1;
            fd_stall_o   = 1'b1;
            de_stall_o   = 1'b1;
            wait_cnt_nxt = wait_cnt + WC_W'(1);
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (pc_stall_o) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign stall_count_o = stall_cnt;

endmodule
